// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (generators 7,5 octal) with a valid/ready bit input and symbol output.
// Define CONV_ENC_TAIL_EN for two zero tail symbols per frame; otherwise the last data symbol ends the frame.
module conv_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             bit_last_i,
  output logic             bit_ready_o,
  output logic             sym_valid_o,
  output logic [1:0]       sym_o,
  output logic             sym_last_o,
  input  logic             sym_ready_i,
  output logic [CNT_W-1:0] frame_bits_o
);

  localparam int unsigned       ST_W    = 2;
  localparam logic [ST_W-1:0]   DATA    = 2'd0;
`ifdef CONV_ENC_TAIL_EN
  localparam logic [ST_W-1:0]   TAIL0   = 2'd1;
  localparam logic [ST_W-1:0]   TAIL1   = 2'd2;
`endif
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [ST_W-1:0]  state_q, state_d;
  logic [1:0]       sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] frame_bits_q, frame_bits_d;
  logic             sym_valid_q, sym_valid_d;
  logic [1:0]       sym_q, sym_d;
  logic             sym_last_q, sym_last_d;
  logic             slot_free;
  logic             bit_ready_c;

  // Trellis label for input u from state {m1,m2}: {u^m1^m2, u^m2}.
  function automatic logic [1:0] encode(input logic u, input logic [1:0] sr);
    return {u ^ sr[1] ^ sr[0], u ^ sr[0]};
  endfunction

  assign slot_free = !sym_valid_q || sym_ready_i;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DATA;
      sr_q         <= 2'b00;
      cnt_q        <= '0;
      frame_bits_q <= '0;
      sym_valid_q  <= 1'b0;
      sym_q        <= 2'b00;
      sym_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      frame_bits_q <= frame_bits_d;
      sym_valid_q  <= sym_valid_d;
      sym_q        <= sym_d;
      sym_last_q   <= sym_last_d;
    end
  end

  // Next-state, slot and counter logic.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    frame_bits_d = frame_bits_q;
    sym_valid_d  = sym_valid_q & ~sym_ready_i;
    sym_d        = sym_q;
    sym_last_d   = sym_last_q & sym_valid_d;
    bit_ready_c  = 1'b0;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      DATA: begin
        bit_ready_c = slot_free;
        if (bit_valid_i && slot_free) begin
          sym_valid_d = 1'b1;
          sym_d       = encode(bit_i, sr_q);
          sym_last_d  = 1'b0;
          sr_d        = {bit_i, sr_q[1]};
          cnt_d       = cnt_inc;
          if (bit_last_i) begin
            frame_bits_d = cnt_inc;
`ifdef CONV_ENC_TAIL_EN
            state_d      = TAIL0;
`else
            // Without tails the frame closes here and the next one starts in S0.
            sym_last_d   = 1'b1;
            sr_d         = 2'b00;
            cnt_d        = '0;
`endif
          end
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL0: begin
        if (slot_free) begin
          sym_valid_d = 1'b1;
          sym_d       = encode(1'b0, sr_q);
          sym_last_d  = 1'b0;
          sr_d        = {1'b0, sr_q[1]};
          state_d     = TAIL1;
        end
      end
      TAIL1: begin
        if (slot_free) begin
          sym_valid_d = 1'b1;
          sym_d       = encode(1'b0, sr_q);
          sym_last_d  = 1'b1;
          sr_d        = 2'b00;
          cnt_d       = '0;
          state_d     = DATA;
        end
      end
`endif
      default: state_d = DATA;
    endcase
  end

  assign bit_ready_o  = bit_ready_c;
  assign sym_valid_o  = sym_valid_q;
  assign sym_o        = sym_q;
  assign sym_last_o   = sym_last_q;
  assign frame_bits_o = frame_bits_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames, trellis sweep, backpressure, reset and
// randomized frames against a sequence-level convolution model. A CNT_W=2 copy checks counter saturation.
module tb_conv_encoder;

`ifdef CONV_ENC_TAIL_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        bit_valid_i, bit_i, bit_last_i, sym_ready_i;
  logic        bit_ready_o, sym_valid_o, sym_last_o;
  logic [1:0]  sym_o;
  logic [15:0] frame_bits_o;
  logic        b2_ready, b2_valid, b2_last;
  logic [1:0]  b2_sym;
  logic [1:0]  b2_frame_bits;

  int n_chk = 0;
  int n_pass = 0;
  logic        acc;
  logic        frame_q[$];
  logic [2:0]  got_q[$];
  logic [2:0]  exp_q[$];

  always #5 clk_i = ~clk_i;

  conv_encoder #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_last_i(bit_last_i), .bit_ready_o(bit_ready_o),
    .sym_valid_o(sym_valid_o), .sym_o(sym_o), .sym_last_o(sym_last_o), .sym_ready_i(sym_ready_i),
    .frame_bits_o(frame_bits_o)
  );

  conv_encoder #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_last_i(bit_last_i), .bit_ready_o(b2_ready),
    .sym_valid_o(b2_valid), .sym_o(b2_sym), .sym_last_o(b2_last), .sym_ready_i(sym_ready_i),
    .frame_bits_o(b2_frame_bits)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: sample handshakes with settled inputs, then advance past the edge.
  task automatic cycle();
    #1;
    if (sym_valid_o && sym_ready_i) got_q.push_back({sym_last_o, sym_o});
    acc = bit_valid_i && bit_ready_o;
    @(posedge clk_i);
    #1;
  endtask

  // Expected stream: c1 = u[k]^u[k-1]^u[k-2], c0 = u[k]^u[k-2], zero history, TAIL zeros appended.
  task automatic build_exp();
    int n, total;
    logic u, m1, m2;
    n = frame_q.size();
    total = n + TAIL;
    exp_q.delete();
    for (int k = 0; k < total; k++) begin
      u  = (k < n) ? frame_q[k] : 1'b0;
      m1 = (k >= 1 && k - 1 < n) ? frame_q[k-1] : 1'b0;
      m2 = (k >= 2 && k - 2 < n) ? frame_q[k-2] : 1'b0;
      exp_q.push_back({k == total - 1, u ^ m1 ^ m2, u ^ m2});
    end
  endtask

  // Drive frame_q, collect symbols until the last one leaves, compare with the model.
  task automatic run_frame(input string tag, input int rdy_pct, input bit gaps, input int stall_at);
    int n, i, budget;
    bit done;
    logic [2:0] held, t;
    n = frame_q.size();
    build_exp();
    got_q.delete();
    i = 0; budget = 0; done = 0; held = '0;
    while (!done && budget < 400) begin
      bit_valid_i = (i < n) && (!gaps || $urandom_range(3) != 0);
      bit_i       = (i < n) ? frame_q[i] : 1'b0;
      bit_last_i  = (i == n - 1);
      sym_ready_i = ($urandom_range(99) < rdy_pct);
      if (budget == stall_at) held = {sym_last_o, sym_o};
      if (budget >= stall_at && budget < stall_at + 3 && stall_at >= 0) sym_ready_i = 1'b0;
      cycle();
      if (budget >= stall_at && budget < stall_at + 3 && stall_at >= 0) begin
        check($sformatf("%s stall sym", tag), {29'd0, sym_last_o, sym_o}, {29'd0, held});
        check($sformatf("%s stall valid", tag), {31'd0, sym_valid_o}, 32'd1);
        check($sformatf("%s stall ready", tag), {31'd0, bit_ready_o}, 32'd0);
      end
      if (acc) i++;
      if (got_q.size() > 0) begin
        t = got_q[got_q.size()-1];
        done = t[2];
      end
      budget++;
    end
    bit_valid_i = 1'b0;
    bit_last_i  = 1'b0;
    check($sformatf("%s done", tag), {31'd0, done}, 32'd1);
    check($sformatf("%s count", tag), got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      t = (k < got_q.size()) ? got_q[k] : 3'bxxx;
      check($sformatf("%s sym%0d", tag, k), {29'd0, t}, {29'd0, exp_q[k]});
    end
    check($sformatf("%s frame_bits", tag), {16'd0, frame_bits_o}, n);
    check($sformatf("%s frame_bits_sat", tag), {30'd0, b2_frame_bits}, (n > 3) ? 3 : n);
    check($sformatf("%s drained", tag), {30'd0, b2_valid, b2_last}, 32'd0);
    check($sformatf("%s idle ready", tag), {31'd0, b2_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0] ref1011 [6];
    logic [1:0] lbl [8];
    logic [2:0] t;
    int n;
    ref1011 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    lbl     = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};

    rst_ni = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0; bit_last_i = 1'b0; sym_ready_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst valid", {31'd0, sym_valid_o}, 32'd0);
    check("rst sym", {30'd0, sym_o}, 32'd0);
    check("rst last", {31'd0, sym_last_o}, 32'd0);
    check("rst frame_bits", {16'd0, frame_bits_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("post-rst ready", {31'd0, bit_ready_o}, 32'd1);

    // Reference frame 1,0,1,1 with hard-coded labels.
    frame_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame("f1011", 100, 0, -1);
    for (int k = 0; k < 4 + TAIL; k++) begin
      t = (k < got_q.size()) ? got_q[k] : 3'bxxx;
      check($sformatf("f1011 label%0d", k), {30'd0, t[1:0]}, {30'd0, ref1011[k]});
    end

    frame_q = '{1'b1};
    run_frame("single", 100, 0, -1);
    frame_q = '{1'b0, 1'b0, 1'b0};
    run_frame("zeros", 100, 0, -1);

    // Every state/input pair: reach {m1,m2} with bits m2,m1 then apply u.
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        frame_q = '{1'(s & 1), 1'(s >> 1), 1'(u)};
        run_frame($sformatf("trel s%0d u%0d", s, u), 100, 0, -1);
        t = (got_q.size() > 2) ? got_q[2] : 3'bxxx;
        check($sformatf("trel label s%0d u%0d", s, u), {30'd0, t[1:0]}, {30'd0, lbl[s*2+u]});
      end
    end

    // Backpressure mid-frame, then a back-to-back frame.
    frame_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    run_frame("stall", 100, 0, 2);
    frame_q = '{1'b0, 1'b1, 1'b1};
    run_frame("b2b", 100, 0, -1);

    // Five-bit frame saturates the CNT_W=2 counter at 3.
    frame_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_frame("sat5", 100, 0, -1);

    // Reset with a held symbol (TAIL0 when tails are enabled).
    sym_ready_i = 1'b1;
    bit_valid_i = 1'b1; bit_i = 1'b1; bit_last_i = 1'b0;
    cycle();
    bit_last_i = (TAIL != 0);
    cycle();
    bit_valid_i = 1'b0; bit_last_i = 1'b0; sym_ready_i = 1'b0;
    cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async rst valid", {31'd0, sym_valid_o}, 32'd0);
    check("async rst sym", {30'd0, sym_o}, 32'd0);
    check("async rst last", {31'd0, sym_last_o}, 32'd0);
    check("async rst frame_bits", {16'd0, frame_bits_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    check("rst release ready", {31'd0, bit_ready_o}, 32'd1);
    frame_q = '{1'b1};
    run_frame("after rst", 100, 0, -1);
    t = (got_q.size() > 0) ? got_q[0] : 3'bxxx;
    check("after rst first", {30'd0, t[1:0]}, 32'd3);

    // Randomized frames with input gaps and random downstream readiness.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(12, 1);
      frame_q.delete();
      for (int k = 0; k < n; k++) frame_q.push_back(1'($urandom_range(1)));
      run_frame($sformatf("rand%0d", f), 40 + 10 * f, 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
